// File: rtl/fetch_ifid_stage_pkg.sv
// Shared types and defaults for the instruction-fetch / IF-ID stage.
package fetch_ifid_stage_pkg;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    WAIT,
    SKID,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_ifid_stage_ifid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer in front of it.
module fetch_ifid_stage_ifid_reg #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              consume,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [ADDR_W-1:0] load_npc,
  output logic              skid_valid,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_npc
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d, npc_q, npc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d, skid_npc_q, skid_npc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= '0;
      npc_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_npc_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_npc_q   <= skid_npc_d;
    end
  end

  // A full skid implies IF/ID is held, so no new load can arrive alongside it.
  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    npc_d        = npc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_npc_d   = skid_npc_q;
    if (flush) begin
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (consume) begin
        valid_d      = 1'b1;
        instr_d      = skid_instr_q;
        pc_d         = skid_pc_q;
        npc_d        = skid_npc_q;
        skid_valid_d = 1'b0;
      end
    end else if (load) begin
      if (!valid_q || consume) begin
        valid_d = 1'b1;
        instr_d = load_instr;
        pc_d    = load_pc;
        npc_d   = load_npc;
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = load_instr;
        skid_pc_d    = load_pc;
        skid_npc_d   = load_npc;
      end
    end else if (valid_q && consume) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  assign skid_valid = skid_valid_q;
  assign ifid_valid = valid_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = pc_q;
  assign ifid_npc   = npc_q;

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage: one outstanding imem request, PC/nPC advance, IF/ID capture.
module fetch_ifid_stage
  import fetch_ifid_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEF_NOP_INSTR)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] nPC,
  input  logic              flush,
  input  logic              id_stall,
  output logic              pc_load,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_npc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d, pend_npc_q, pend_npc_d;
  logic              skid_valid;
  logic              fetch_ok, grant, rsp_load, ifid_free;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= BOOT;
      pend_pc_q  <= '0;
      pend_npc_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_pc_q  <= pend_pc_d;
      pend_npc_q <= pend_npc_d;
    end
  end

  // A gnt seen together with flush still counts as accepted by memory, so its
  // response must be drained even though pc_load is suppressed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (flush)      state_d = (fetch_ok && imem_gnt) ? DRAIN : FETCH;
        else if (grant) state_d = WAIT;
      end
      WAIT: begin
        if (flush)            state_d = imem_rvalid ? FETCH : DRAIN;
        else if (imem_rvalid) state_d = ifid_free ? FETCH : SKID;
      end
      SKID: begin
        if (flush || !id_stall) state_d = FETCH;
      end
      DRAIN: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    ifid_free  = !ifid_valid || !id_stall;
    fetch_ok   = (state_q == FETCH) && !skid_valid && !(ifid_valid && id_stall);
    imem_req   = fetch_ok && !flush;
    imem_addr  = PC;
    grant      = imem_req && imem_gnt;
    pc_load    = grant;
    rsp_load   = (state_q == WAIT) && imem_rvalid && !flush;
    pend_pc_d  = grant ? PC  : pend_pc_q;
    pend_npc_d = grant ? nPC : pend_npc_q;
  end

  fetch_ifid_stage_ifid_reg #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk        (Clk),
    .rst_n      (Reset),
    .flush      (flush),
    .load       (rsp_load),
    .consume    (!id_stall),
    .load_instr (imem_rdata),
    .load_pc    (pend_pc_q),
    .load_npc   (pend_npc_q),
    .skid_valid (skid_valid),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_npc   (ifid_npc)
  );

  // A response is only legal while one is outstanding.
  a_rvalid_expected: assert property (@(posedge Clk) disable iff (!Reset)
    imem_rvalid |-> (state_q == WAIT || state_q == DRAIN));

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
Instruction-fetch stage that sits directly downstream of the PC/nPC register pair.
- Issues one instruction-memory request per PC value.
- Returns a load enable that advances both PC and nPC.
- Captures the returned instruction with its PC/nPC into the IF/ID pipeline register.
- Handles decode back-pressure through a one-entry skid buffer, and squashes wrong-path fetches on flush.

Parameters:
ADDR_W, 32, width of PC/nPC and memory address
DATA_W, 32, instruction width
NOP_INSTR, 32'h0000_0000, instruction value placed in IF/ID when it is empty or flushed

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
PC  in  ADDR_W  current PC from the PC register
nPC  in  ADDR_W  current nPC from the nPC register
flush  in  1  squash all fetched and in-flight instructions (taken branch or exception redirect)
id_stall  in  1  decode cannot accept the IF/ID contents this cycle
pc_load  out  1  enable to the PC and nPC registers (PC<=nPC, nPC<=nPC+4)
imem_req  out  1  request valid
imem_addr  out  ADDR_W  request address; always equals PC
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  DATA_W  instruction word
ifid_valid  out  1  IF/ID holds a live instruction
ifid_instr  out  DATA_W  IF/ID instruction
ifid_pc  out  ADDR_W  PC of the IF/ID instruction
ifid_npc  out  ADDR_W  nPC captured alongside it (delay-slot successor)

Behaviour:
- Reset low (asynchronous):
  - state=BOOT; ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_npc=0.
  - skid empty, pend_pc/pend_npc=0.
  - imem_req=0 and pc_load=0 while Reset is low.
- BOOT: lasts one cycle after Reset rises, so the synchronously reset PC/nPC registers settle. Then go to FETCH.
- Request condition: imem_req = (state==FETCH) & !skid_valid & !(ifid_valid & id_stall) & !flush. This is combinational.
- Grant: a grant is imem_req & imem_gnt.
  - pc_load=1 for exactly that cycle.
  - PC and nPC are latched into pend_pc/pend_npc.
  - Next state is WAIT.
  - Only one request is outstanding at any time.
- pc_load is never asserted in any other case, and never while flush=1. Redirect logic owns PC/nPC in a flush cycle.
- WAIT, on imem_rvalid:
  - If IF/ID is free (!ifid_valid | !id_stall): load IF/ID with {1, rdata, pend_pc, pend_npc}, go to FETCH.
  - Otherwise: write the same tuple into the skid buffer, go to SKID.
- SKID:
  - When id_stall=0: skid moves into IF/ID, skid is cleared, go to FETCH.
  - No request is issued while in SKID.
- Consumption: if ifid_valid & !id_stall and nothing new is loaded that cycle, then ifid_valid<=0 and ifid_instr<=NOP_INSTR.
- Latency: an instruction whose response arrives in cycle N is visible in IF/ID at N+1.
  - With a zero-wait memory (grant N, rvalid N+1), sustained throughput is one instruction per two cycles.
- Flush (highest priority, takes effect at the next edge):
  - ifid_valid<=0, ifid_instr<=NOP_INSTR, skid cleared.
  - If state is WAIT, or a grant occurs in the same cycle: go to DRAIN. Otherwise go to FETCH.
- DRAIN: discard the next imem_rvalid, then go to FETCH.
  - A flush while in DRAIN stays in DRAIN.
  - rvalid coinciding with flush while in WAIT counts as the drained response: go to FETCH.
- rvalid in FETCH, BOOT or SKID is a protocol error. It is ignored, and a simulation-only assertion flags it.
- id_stall and flush together: flush wins.

Decomposition:
- Shared package: fetch state enum {BOOT, FETCH, WAIT, SKID, DRAIN}; NOP_INSTR constant; ADDR_W/DATA_W defaults.
- Sub-module ifid_reg: holds the IF/ID register plus the one-entry skid buffer, with load/consume/flush inputs.
- The top level keeps the FSM and the request/grant logic.

Test Plan:
- Reset release, memory grants every request and responds one cycle later with 0x20080001, 0x20090002 → first imem_req with addr 0x0 at the 2nd cycle after release; pc_load pulses; IF/ID shows (0x20080001, pc 0, npc 4), then (0x20090002, pc 4, npc 8).
- id_stall held high for 3 cycles while a response is pending → response goes to skid; imem_req stays 0; IF/ID holds the old instruction; on stall release the skid instruction appears next cycle and exactly one pc_load follows.
- flush in the cycle of a grant to PC 0x10 → pc_load=0; state DRAIN; the next response 0xDEADBEEF is discarded; ifid_valid=0; the next fetch uses the redirected PC.
- flush while both skid and IF/ID are valid → both invalidated next cycle; ifid_instr=NOP_INSTR; no instruction ever emerges with pc 0x8 or 0xC.
- imem_gnt held low 5 cycles → imem_req stays high with a stable imem_addr; pc_load stays 0 until the grant.
- Reset asserted mid-WAIT → outputs return to reset values immediately (asynchronous); the late rvalid after release is flagged and ignored.
